// File: rtl/harmonic_scheduler.sv
// harmonic_scheduler: once per sample tick, walks harmonics 0..count, pulls each
// sine sample from the position block, scales it by a geometrically decaying
// level and accumulates a signed mix that is published at the end of the frame.
module harmonic_scheduler #(
  parameter int NYQUIST_LIMIT = 32768,
  parameter int SUM_WIDTH     = 24,
  parameter int LUT_LATENCY   = 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_sample_tick,
  input  logic [15:0]                 i_frequency,
  input  logic [7:0]                  i_harmonic_count,
  input  logic [7:0]                  i_level_scale,
  input  logic                        i_sample_ready,
  input  logic signed [15:0]          i_sample_value,
  output logic [7:0]                  o_harmonic,
  output logic                        o_next_sample,
  output logic signed [SUM_WIDTH-1:0] o_mix,
  output logic                        o_mix_valid,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(LUT_LATENCY + 2);

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, LATCH, SCALE, ADVANCE, GAP, DONE
  } state_t;

  state_t state, state_next;

  // Frame parameters captured at the tick so the caller may change inputs mid-frame.
  logic [15:0]                 frequency_q;
  logic [7:0]                  count_q;
  logic [COEF_W-1:0]           scale_q;
  // Per-harmonic working state.
  logic [7:0]                  h_q;
  logic [COEF_W-1:0]           level_q;
  logic [16:0]                 hfreq_q;
  logic signed [DATA_W-1:0]    sample_q;
  logic signed [SUM_WIDTH-1:0] sum_q;
  logic [CNT_W-1:0]            lat_cnt;
  logic                        last_q;

  logic signed [DATA_W-1:0]    term;
  logic [COEF_W-1:0]           level_new;
  logic [16:0]                 hfreq_new;
  logic                        is_last;

  // Signed sample times unsigned level, arithmetic shift drops the 8 fraction bits.
  function automatic logic signed [DATA_W-1:0] scale_term(
    input logic signed [DATA_W-1:0] s,
    input logic [COEF_W-1:0]        lvl
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'($signed({1'b0, lvl}));
    return DATA_W'(prod >>> COEF_W);
  endfunction

  // Geometric decay of the level; truncating toward zero lets it reach 0.
  function automatic logic [COEF_W-1:0] decay(
    input logic [COEF_W-1:0] lvl,
    input logic [COEF_W-1:0] sc
  );
    logic [2*COEF_W-1:0] p;
    p = (2*COEF_W)'(lvl) * (2*COEF_W)'(sc);
    return p[2*COEF_W-1:COEF_W];
  endfunction

  // Scaling arithmetic and the end-of-frame decision, consumed in SCALE.
  always_comb begin
    term      = scale_term(sample_q, level_q);
    level_new = decay(level_q, scale_q);
    hfreq_new = hfreq_q + {1'b0, frequency_q};
    is_last   = (h_q == count_q) || (hfreq_new >= 17'(NYQUIST_LIMIT)) || (level_new == '0);
  end

  // Next-state logic; the LUT latency counter starts on the first ready.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (i_sample_tick) state_next = WAIT_READY;
      WAIT_READY: if ((i_sample_ready || lat_cnt != '0) && lat_cnt == CNT_W'(LUT_LATENCY))
                    state_next = LATCH;
      LATCH:      state_next = SCALE;
      SCALE:      state_next = ADVANCE;
      ADVANCE:    state_next = last_q ? DONE : GAP;
      GAP:        state_next = WAIT_READY;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Control state and registered outputs; the harmonic/next_sample pair is loaded
  // on the SCALE edge so both are visible together during ADVANCE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      last_q        <= 1'b0;
      h_q           <= '0;
      o_harmonic    <= '0;
      o_next_sample <= 1'b0;
      o_mix         <= '0;
      o_mix_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_next;
      o_busy        <= (state_next != IDLE);
      o_overrun     <= i_sample_tick && (state != IDLE);
      o_next_sample <= (state == SCALE);
      o_mix_valid   <= (state == DONE);
      if (state == DONE) o_mix <= sum_q;
      if (state == WAIT_READY) begin
        if (state_next == LATCH) lat_cnt <= '0;
        else if (i_sample_ready || lat_cnt != '0) lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= '0;
      end
      if (state == IDLE && i_sample_tick) h_q <= '0;
      if (state == SCALE) begin
        last_q <= is_last;
        if (is_last) begin
          o_harmonic <= '0;
        end else begin
          o_harmonic <= h_q + 8'd1;
          h_q        <= h_q + 8'd1;
        end
      end
    end
  end

  // Datapath registers: initialised at the tick, so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (state == IDLE && i_sample_tick) begin
      frequency_q <= i_frequency;
      count_q     <= i_harmonic_count;
      scale_q     <= i_level_scale;
      sum_q       <= '0;
      level_q     <= '1;
      hfreq_q     <= {1'b0, i_frequency};
    end
    if (state == LATCH) sample_q <= i_sample_value;
    if (state == SCALE) begin
      sum_q   <= sum_q + SUM_WIDTH'(term);
      level_q <= level_new;
      if (!is_last) hfreq_q <= hfreq_new;
    end
  end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Bench for harmonic_scheduler: a behavioural position block feeds samples from
// a per-frame table, and a frame-level reference model predicts the mix, the
// harmonic handshake sequence, busy and overrun on every cycle.
module tb_harmonic_scheduler;

  localparam int LUT_LATENCY = 1;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_sample_tick;
  logic [15:0] i_frequency;
  logic [7:0]  i_harmonic_count;
  logic [7:0]  i_level_scale;
  logic        i_sample_ready;
  logic signed [15:0] i_sample_value;
  logic [7:0]  o_harmonic;
  logic        o_next_sample;
  logic [23:0] o_mix;
  logic        o_mix_valid;
  logic        o_busy;
  logic        o_overrun;

  harmonic_scheduler #(
    .NYQUIST_LIMIT(32768),
    .SUM_WIDTH(24),
    .LUT_LATENCY(LUT_LATENCY)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_sample_tick(i_sample_tick),
    .i_frequency(i_frequency),
    .i_harmonic_count(i_harmonic_count),
    .i_level_scale(i_level_scale),
    .i_sample_ready(i_sample_ready),
    .i_sample_value(i_sample_value),
    .o_harmonic(o_harmonic),
    .o_next_sample(o_next_sample),
    .o_mix(o_mix),
    .o_mix_valid(o_mix_valid),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  logic signed [15:0] tbl [0:255];
  int n_checks = 0;
  int n_errors = 0;
  int pin_mix;
  int pin_terms;
  bit pin_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: sums harmonics until count, Nyquist or a zero level.
  function automatic void ref_frame(input int f, input int c, input int s,
                                    output int mix, output int nt);
    int lvl, hf, t;
    lvl = 255; hf = f; mix = 0; nt = 0;
    for (int h = 0; h <= c; h++) begin
      t   = (int'(tbl[h]) * lvl) >>> 8;
      mix += t;
      nt  = h + 1;
      lvl = (lvl * s) / 256;
      hf  += f;
      if (h == c || hf >= 32768 || lvl == 0) break;
    end
  endfunction

  // Position block model: drops ready on the consuming edge, re-raises it after a
  // random delay, and only presents the real sample LUT_LATENCY cycles later.
  int  pb_dly, pb_lat;
  bit  pb_prev_ns;
  initial begin
    i_sample_ready = 1'b0;
    i_sample_value = 16'h0;
    pb_dly = 1; pb_lat = 0; pb_prev_ns = 1'b0;
    forever begin
      @(posedge i_clock); #2;
      if (i_reset) begin
        i_sample_ready = 1'b0;
        i_sample_value = 16'($urandom);
        pb_dly = 1;
        pb_prev_ns = 1'b0;
      end else begin
        if (pb_prev_ns) begin
          i_sample_ready = 1'b0;
          i_sample_value = 16'($urandom);
          pb_dly = $urandom_range(1, 3);
        end else if (!i_sample_ready) begin
          if (pb_dly > 1) pb_dly--;
          else begin
            i_sample_ready = 1'b1;
            pb_lat = 0;
            i_sample_value = (LUT_LATENCY == 0) ? tbl[o_harmonic] : 16'($urandom);
          end
        end else begin
          if (pb_lat < 100) pb_lat++;
          if (pb_lat >= LUT_LATENCY) i_sample_value = tbl[o_harmonic];
        end
        pb_prev_ns = o_next_sample;
      end
    end
  end

  // Per-cycle compare process.
  bit in_frame = 1'b0;
  bit exp_ovr = 1'b0;
  bit prev_ns = 1'b0;
  bit rst_prev = 1'b0;
  int exp_mix = 0;
  int last_mix = 0;
  int cur_h = 0;
  int frame_cycles = 0;
  int nterms = 0;
  int hq[$];
  initial begin
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        in_frame = 1'b0; exp_ovr = 1'b0; prev_ns = 1'b0;
        last_mix = 0; cur_h = 0; frame_cycles = 0;
        hq.delete();
        rst_prev = 1'b1;
        continue;
      end
      if (rst_prev) begin
        chk("reset_harmonic", int'(o_harmonic), 0);
        chk("reset_next_sample", int'(o_next_sample), 0);
        chk("reset_mix", int'(o_mix), 0);
        chk("reset_mix_valid", int'(o_mix_valid), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_overrun", int'(o_overrun), 0);
        rst_prev = 1'b0;
      end
      chk("overrun", int'(o_overrun), int'(exp_ovr));
      if (o_next_sample) begin
        chk("next_sample_width", int'(prev_ns), 0);
        if (hq.size() == 0) chk("next_sample_unexpected", int'(o_next_sample), 0);
        else cur_h = hq.pop_front();
      end
      chk("harmonic", int'(o_harmonic), cur_h);
      if (o_mix_valid) begin
        if (!in_frame) begin
          chk("mix_valid_unexpected", int'(o_mix_valid), 0);
        end else begin
          chk("mix", int'(o_mix), exp_mix & 24'hFFFFFF);
          chk("terms_outstanding", hq.size(), 0);
          if (pin_valid) begin
            chk("pin_model_mix", exp_mix, pin_mix);
            chk("pin_model_terms", nterms, pin_terms);
            chk("pin_dut_mix", int'(o_mix), pin_mix & 24'hFFFFFF);
          end
          last_mix = exp_mix & 24'hFFFFFF;
          in_frame = 1'b0;
        end
      end else begin
        chk("mix_hold", int'(o_mix), last_mix);
      end
      chk("busy", int'(o_busy), int'(in_frame));
      if (in_frame) begin
        frame_cycles++;
        if (frame_cycles > 6000) begin
          chk("frame_timeout", frame_cycles, 6000);
          in_frame = 1'b0;
          hq.delete();
        end
      end
      exp_ovr = 1'b0;
      if (i_sample_tick) begin
        if (in_frame) exp_ovr = 1'b1;
        else begin
          in_frame = 1'b1;
          frame_cycles = 0;
          ref_frame(int'(i_frequency), int'(i_harmonic_count), int'(i_level_scale), exp_mix, nterms);
          hq.delete();
          for (int k = 1; k < nterms; k++) hq.push_back(k);
          hq.push_back(0);
        end
      end
      prev_ns = o_next_sample;
    end
  end

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 256; i++) tbl[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) tbl[i] = 16'($urandom);
  endtask

  // One-cycle tick; inputs are scrambled afterwards to prove they were latched.
  task automatic tick_frame(input int f, input int c, input int s);
    i_frequency = 16'(f);
    i_harmonic_count = 8'(c);
    i_level_scale = 8'(s);
    i_sample_tick = 1'b1;
    @(posedge i_clock); #1;
    i_sample_tick = 1'b0;
    i_frequency = 16'($urandom);
    i_harmonic_count = 8'($urandom);
    i_level_scale = 8'($urandom);
  endtask

  task automatic wait_mix();
    int n;
    n = 0;
    while (n < 8000) begin
      @(posedge i_clock); #1;
      n++;
      if (o_mix_valid) break;
    end
    repeat (2) @(posedge i_clock);
    #1;
  endtask

  task automatic set_pin(input int m, input int t);
    pin_mix = m; pin_terms = t; pin_valid = 1'b1;
  endtask

  int f, c, s;
  initial begin
    i_reset = 1'b1;
    i_sample_tick = 1'b0;
    i_frequency = 16'd0;
    i_harmonic_count = 8'd0;
    i_level_scale = 8'd0;
    fill_const(16'h1000);
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b0;
    repeat (4) @(posedge i_clock);
    #1;

    // Four terms, levels 255..252.
    fill_const(16'h1000);
    set_pin(16224, 4);
    tick_frame(100, 3, 255); wait_mix();
    // Nyquist stop after three terms.
    set_pin(12192, 3);
    tick_frame(10000, 10, 255); wait_mix();
    // Level decays to zero after one term.
    set_pin(4080, 1);
    tick_frame(100, 5, 0); wait_mix();
    // Negative sample, single term.
    fill_const(16'hF000);
    set_pin(-4080, 1);
    tick_frame(100, 0, 255); wait_mix();
    // Nyquist exactly at the limit on the second harmonic.
    fill_const(16'h1000);
    set_pin(4080, 1);
    tick_frame(16384, 9, 255); wait_mix();
    set_pin(8144, 2);
    tick_frame(16383, 9, 255); wait_mix();

    // Overrun: second tick five cycles into a frame must not disturb it.
    set_pin(16224, 4);
    tick_frame(100, 3, 255);
    repeat (4) @(posedge i_clock);
    #1;
    i_frequency = 16'd5000; i_harmonic_count = 8'd7; i_level_scale = 8'd100;
    i_sample_tick = 1'b1;
    @(posedge i_clock); #1;
    i_sample_tick = 1'b0;
    wait_mix();
    pin_valid = 1'b0;

    // Reset mid-frame, then a clean frame.
    tick_frame(100, 3, 255);
    repeat (6) @(posedge i_clock);
    #1 i_reset = 1'b1;
    @(posedge i_clock); #1 i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    set_pin(16224, 4);
    tick_frame(100, 3, 255); wait_mix();
    pin_valid = 1'b0;

    // Full-length frames with extreme samples.
    fill_const(16'h7FFF);
    tick_frame(1, 255, 255); wait_mix();
    fill_const(16'h8000);
    tick_frame(0, 255, 255); wait_mix();

    // Randomised frames.
    for (int r = 0; r < 40; r++) begin
      fill_rand();
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4000);
      c = $urandom_range(0, 24);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(224, 255);
      tick_frame(f, c, s);
      wait_mix();
    end

    repeat (3) @(posedge i_clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/harmonic_scheduler.md
# harmonic_scheduler

Sequences the per-harmonic sample-position/sine-LUT datapath once per output sample. On each sample-rate tick it walks harmonics 0..N, handshakes each sine sample out of the position block, scales it by a geometrically decaying level, and accumulates a signed mix. It stops early at Nyquist or when the level decays to zero, then publishes the mix to the output stage.

## Interface
- NYQUIST_LIMIT, 32768: harmonic phase increment at or above this is not summed
- SUM_WIDTH, 24: mix accumulator/output width
- LUT_LATENCY, 1: cycles from first `i_sample_ready` high to valid `i_sample_value`

- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_sample_tick  in  1  one-cycle strobe: start a frame
- i_frequency  in  16  fundamental phase increment (same value fed to position block)
- i_harmonic_count  in  8  highest harmonic index to sum (count+1 terms)
- i_level_scale  in  8  per-harmonic decay factor, level_next = (level*scale)>>8
- i_sample_ready  in  1  position block has a sample for `o_harmonic`
- i_sample_value  in  16  signed sine sample
- o_harmonic  out  8  harmonic index driven to position block
- o_next_sample  out  1  one-cycle pulse: current sample consumed, advance
- o_mix  out  SUM_WIDTH  signed mix of last completed frame
- o_mix_valid  out  1  one-cycle pulse when `o_mix` updates
- o_busy  out  1  high in every state except IDLE
- o_overrun  out  1  one-cycle pulse: tick arrived while busy

## Operation
- States: IDLE, WAIT_READY, LATCH, SCALE, ADVANCE, GAP, DONE.
- IDLE: `o_harmonic`=0. On tick: sum<=0, level<=255, hfreq<=i_frequency (17-bit), h<=0 -> WAIT_READY. Inputs frequency/count/scale latched at tick, held for the frame.
- WAIT_READY: on `i_sample_ready`=1, wait LUT_LATENCY cycles, then LATCH captures `i_sample_value`.
- SCALE: term = (sample * {1'b0,level}) >>> 8 (24-bit signed product, arithmetic shift, 16-bit signed result); sum += sign-extended term; level <= (level*scale)>>8; next_hfreq = hfreq + frequency.
- ADVANCE: last if h == count, or next_hfreq >= NYQUIST_LIMIT, or new level == 0. Not last: o_harmonic<=h+1, h<=h+1, hfreq<=next_hfreq. Last: o_harmonic<=0. Both: o_next_sample=1 for exactly one cycle, `o_harmonic` valid in that same cycle. Not last -> GAP; last -> DONE.
- GAP: one cycle, `i_sample_ready` ignored (position block drops ready on the consuming edge), -> WAIT_READY.
- DONE: o_mix<=sum, o_mix_valid=1 for one cycle -> IDLE.
- Ending with `o_harmonic`=0 makes the position block restart its accumulator and pre-fetch harmonic 0 for the next frame.
- Tick while not IDLE: ignored, `o_overrun` pulses same cycle it is seen; frame continues unaffected.
- Sum never saturates: 256 terms x 16 bits fit in 24 bits.

## Timing
- Reset values: o_harmonic=0, o_next_sample=0, o_mix=0, o_mix_valid=0, o_busy=0, o_overrun=0, state IDLE.
- All outputs registered.
- Reset mid-frame: abandon frame, `o_mix` returns to 0, no `o_mix_valid`; position block shares reset, so the pair restarts aligned.
- Per harmonic: WAIT_READY (>=1) + LUT_LATENCY + LATCH + SCALE + ADVANCE + GAP cycles; frame ends with DONE then IDLE.
- Tick accepted the cycle after IDLE is re-entered (not in DONE).

## Test plan
- Bench model of position block returns constant 0x1000; freq=100, count=3, scale=255, tick -> levels 255,254,253,252, o_mix=16224 (0x003F60), one o_mix_valid, four o_next_sample pulses, o_harmonic sequence 1,2,3,0.
- freq=10000, count=10, scale=255, sample 0x1000 -> Nyquist stop after 3 terms, o_mix=12192, last o_next_sample with o_harmonic=0.
- scale=0, count=5, sample 0x1000 -> one term, o_mix=4080.
- sample 0xF000, count=0, scale=255 -> o_mix=0xFFF010 (-4080), o_next_sample pulses once with o_harmonic=0.
- Second tick 5 cycles into a frame -> o_overrun single pulse, o_mix identical to undisturbed frame.
- Reset asserted mid-frame -> all outputs at reset values next cycle; following tick yields correct mix from first test.
